// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between the pipeline MEM stage (P) and a debug/loader port (D).
// Default arbitration is P priority with a starvation guard; define ARB_RR_EN for round-robin.
module dmem_port_arbiter #(
  parameter int M          = 32,
  parameter int ADDR_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              p_req,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [M-1:0]      p_wdata,
  output logic [M-1:0]      p_rdata,
  output logic              p_ack,
  output logic              p_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [M-1:0]      d_wdata,
  output logic [M-1:0]      d_rdata,
  output logic              d_ack,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [M-1:0]      mem_wdata,
  input  logic [M-1:0]      mem_rdata,
  output logic              busy
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              win_d;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [M-1:0]      lat_wdata;
  logic              grant_d;

`ifdef ARB_RR_EN
  logic last_d;
  // Tie goes to whoever was not granted last; pointer resets to P so D wins first.
  always_comb grant_d = d_req & (~p_req | ~last_d);
`else
  localparam int SC_W = $clog2(STARVE_MAX + 1);
  logic [SC_W-1:0] scnt;
  always_comb grant_d = d_req & (~p_req | (scnt == SC_W'(STARVE_MAX)));
`endif

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= IDLE;
      cnt       <= '0;
      win_d     <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      mem_we    <= 1'b0;
      p_ack     <= 1'b0;
      d_ack     <= 1'b0;
      p_rdata   <= '0;
      d_rdata   <= '0;
`ifdef ARB_RR_EN
      last_d    <= 1'b0;
`else
      scnt      <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      p_ack  <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (p_req | d_req) begin
            state     <= ACCESS;
            win_d     <= grant_d;
            lat_we    <= grant_d ? d_we    : p_we;
            lat_addr  <= grant_d ? d_addr  : p_addr;
            lat_wdata <= grant_d ? d_wdata : p_wdata;
            mem_we    <= grant_d ? d_we    : p_we;
            cnt       <= CNT_W'(RD_LAT - 1);
`ifdef ARB_RR_EN
            last_d    <= grant_d;
`endif
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            state <= RESP;
            // Read data is sampled on the way into RESP and held until that side's next read.
            if (!lat_we) begin
              if (win_d) d_rdata <= mem_rdata;
              else       p_rdata <= mem_rdata;
            end
            if (win_d) d_ack <= 1'b1;
            else       p_ack <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
`ifndef ARB_RR_EN
      if (!d_req)              scnt <= '0;
      else if (state == IDLE)  scnt <= grant_d ? '0 : scnt + SC_W'(1);
`endif
    end
  end

  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign busy      = (state != IDLE);
  assign p_stall   = p_req & ~p_ack;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: vector table, directed corner sequences, and a
// randomized run against a transaction-level reference model.
module tb_dmem_port_arbiter;
  localparam int RL  = 1;
  localparam int RL3 = 3;
  localparam int SM  = 4;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic rst, p_req, p_we, p_ack, p_stall, d_req, d_we, d_ack, mem_we, busy;
  logic [31:0] p_addr, p_wdata, p_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic rst3, p_req3, p_we3, p_ack3, p_stall3, d_req3, d_we3, d_ack3, mem_we3, busy3;
  logic [31:0] p_addr3, p_wdata3, p_rdata3, d_addr3, d_wdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;

  logic [31:0] mem [16];
  logic [31:0] mem3 [16];
  assign mem_rdata  = mem[mem_addr[3:0]];
  assign mem_rdata3 = mem3[mem_addr3[3:0]];
  always @(posedge CLK)
    if (!rst) for (int i = 0; i < 16; i++) mem[i] <= '0;
    else if (mem_we) mem[mem_addr[3:0]] <= mem_wdata;
  always @(posedge CLK)
    if (!rst3) for (int i = 0; i < 16; i++) mem3[i] <= '0;
    else if (mem_we3) mem3[mem_addr3[3:0]] <= mem_wdata3;

  dmem_port_arbiter #(.M(32), .ADDR_W(32), .RD_LAT(RL), .STARVE_MAX(SM)) dut (
    .CLK(CLK), .RST(rst),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_rdata(p_rdata), .p_ack(p_ack), .p_stall(p_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy));

  dmem_port_arbiter #(.M(32), .ADDR_W(32), .RD_LAT(RL3), .STARVE_MAX(SM)) dut3 (
    .CLK(CLK), .RST(rst3),
    .p_req(p_req3), .p_we(p_we3), .p_addr(p_addr3), .p_wdata(p_wdata3),
    .p_rdata(p_rdata3), .p_ack(p_ack3), .p_stall(p_stall3),
    .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
    .d_rdata(d_rdata3), .d_ack(d_ack3),
    .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .busy(busy3));

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  typedef struct {
    bit          d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t tv [8];

  // reference model state (transaction level)
  int          tl, ms;
  bit          mw, mwe, mlast, gd, was_idle, ep, ed;
  logic [31:0] maddr, mwdata;
  logic [31:0] mrd [2];
  logic [31:0] mm [16];

  initial begin
    int n;
    logic [31:0] last_p, last_d;
    rst = 1'b0; rst3 = 1'b0;
    {p_req, p_we, d_req, d_we} = '0; {p_addr, p_wdata, d_addr, d_wdata} = '0;
    {p_req3, p_we3, d_req3, d_we3} = '0; {p_addr3, p_wdata3, d_addr3, d_wdata3} = '0;

    // reset held with both requests high
    p_req = 1'b1; d_req = 1'b1; p_addr = 32'd9; d_addr = 32'd10;
    @(negedge CLK);
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("rst_mem_we%0d", c), mem_we, 0);
      chk($sformatf("rst_p_ack%0d", c), p_ack, 0);
      chk($sformatf("rst_d_ack%0d", c), d_ack, 0);
      chk($sformatf("rst_busy%0d", c), busy, 0);
      chk($sformatf("rst_p_rdata%0d", c), p_rdata, 0);
      chk($sformatf("rst_d_rdata%0d", c), d_rdata, 0);
      chk($sformatf("rst_p_stall%0d", c), p_stall, 1);
    end
    rst = 1'b1;
    step();
    chk("first_grant_busy", busy, 1);
    chk("first_grant_addr", mem_addr, 32'd9);
    n = 1;
    while (!(p_ack | d_ack) && n < 10) begin step(); n++; end
    chk("first_grant_p_ack", p_ack, 1);
    chk("first_grant_d_ack", d_ack, 0);
    p_req = 1'b0; d_req = 1'b0;
    step(); step();

    // single transactions from a table
    tv[0] = '{d:1'b0, we:1'b1, addr:32'd5,  wdata:32'hDEADBEEF, exp:32'h0};
    tv[1] = '{d:1'b0, we:1'b0, addr:32'd5,  wdata:32'h0,        exp:32'hDEADBEEF};
    tv[2] = '{d:1'b1, we:1'b0, addr:32'd5,  wdata:32'h0,        exp:32'hDEADBEEF};
    tv[3] = '{d:1'b1, we:1'b1, addr:32'd7,  wdata:32'hCAFEF00D, exp:32'h0};
    tv[4] = '{d:1'b0, we:1'b0, addr:32'd7,  wdata:32'h0,        exp:32'hCAFEF00D};
    tv[5] = '{d:1'b1, we:1'b0, addr:32'd0,  wdata:32'h0,        exp:32'h0};
    tv[6] = '{d:1'b0, we:1'b1, addr:32'd15, wdata:32'hFFFFFFFF, exp:32'h0};
    tv[7] = '{d:1'b1, we:1'b0, addr:32'd15, wdata:32'h0,        exp:32'hFFFFFFFF};
    last_p = 32'h0; last_d = 32'h0;
    for (int i = 0; i < 8; i++) begin
      if (tv[i].d) begin d_req = 1'b1; d_we = tv[i].we; d_addr = tv[i].addr; d_wdata = tv[i].wdata; end
      else         begin p_req = 1'b1; p_we = tv[i].we; p_addr = tv[i].addr; p_wdata = tv[i].wdata; end
      step();
      chk($sformatf("tv%0d_stall", i), p_stall, !tv[i].d);
      chk($sformatf("tv%0d_mem_we", i), mem_we, tv[i].we);
      chk($sformatf("tv%0d_addr", i), mem_addr, tv[i].addr);
      n = 1;
      while (!(p_ack | d_ack) && n < 10) begin step(); n++; end
      chk($sformatf("tv%0d_latency", i), n, RL + 1);
      chk($sformatf("tv%0d_ack_side", i), d_ack, tv[i].d);
      if (!tv[i].we) begin
        if (tv[i].d) last_d = tv[i].exp; else last_p = tv[i].exp;
      end
      chk($sformatf("tv%0d_p_rdata", i), p_rdata, last_p);
      chk($sformatf("tv%0d_d_rdata", i), d_rdata, last_d);
      p_req = 1'b0; d_req = 1'b0;
      step();
    end

    // simultaneous P write / D read of the same address
    p_req = 1'b1; p_we = 1'b1; p_addr = 32'd3; p_wdata = 32'h12345678;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'd3;
    step();
    chk("sim_mem_we", mem_we, 1);
    chk("sim_mem_addr", mem_addr, 32'd3);
    chk("sim_mem_wdata", mem_wdata, 32'h12345678);
    step();
    chk("sim_mem_we_off", mem_we, 0);
    chk("sim_p_ack", p_ack, 1);
    chk("sim_d_ack_early", d_ack, 0);
    p_req = 1'b0;
    step();
    chk("sim_idle_gap", busy, 0);
    step();
    chk("sim_d_granted", busy, 1);
    chk("sim_d_no_we", mem_we, 0);
    step();
    chk("sim_d_ack", d_ack, 1);
    chk("sim_d_rdata", d_rdata, 32'h12345678);
    d_req = 1'b0;
    step(); step();

    // continuous contention on both sides
    p_req = 1'b1; p_we = 1'b0; p_addr = 32'd1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'd2;
    for (int g = 0; g < 10; g++) begin
      n = 0;
      while (!(p_ack | d_ack) && n < 10) begin step(); n++; end
`ifdef ARB_RR_EN
      chk($sformatf("rr_grant%0d_is_d", g), d_ack, (g % 2) == 0);
`else
      chk($sformatf("starve_grant%0d_is_d", g), d_ack, (g % 5) == 4);
`endif
      step();
    end
    p_req = 1'b0; d_req = 1'b0;
    step(); step();

    // reset in the middle of a RD_LAT=3 read
    rst3 = 1'b1;
    step();
    d_req3 = 1'b1; d_we3 = 1'b0; d_addr3 = 32'd1;
    step();
    chk("mid_busy_a1", busy3, 1);
    step();
    chk("mid_busy_a2", busy3, 1);
    chk("mid_no_ack_a2", d_ack3, 0);
    rst3 = 1'b0;
    step();
    chk("mid_busy_after_rst", busy3, 0);
    chk("mid_d_rdata_rst", d_rdata3, 0);
    rst3 = 1'b1; d_req3 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      chk($sformatf("mid_no_d_ack%0d", c), d_ack3, 0);
    end
    p_req3 = 1'b1; p_we3 = 1'b1; p_addr3 = 32'd4; p_wdata3 = 32'hA5A5C3C3;
    step();
    chk("mid_wr_mem_we", mem_we3, 1);
    n = 1;
    while (!p_ack3 && n < 12) begin step(); n++; end
    chk("mid_wr_latency", n, RL3 + 1);
    p_req3 = 1'b0;
    step();
    chk("mid_wr_mem", mem3[4], 32'hA5A5C3C3);
    p_req3 = 1'b1; p_we3 = 1'b0;
    step();
    n = 1;
    while (!p_ack3 && n < 12) begin step(); n++; end
    chk("mid_rd_latency", n, RL3 + 1);
    chk("mid_rd_data", p_rdata3, 32'hA5A5C3C3);
    p_req3 = 1'b0;
    step();

    // randomized run against the reference model, starting from a fresh reset
    rst = 1'b0;
    step();
    rst = 1'b1;
    tl = 0; ms = 0; mw = 1'b0; mwe = 1'b0; mlast = 1'b0;
    maddr = '0; mwdata = '0; mrd[0] = '0; mrd[1] = '0;
    for (int i = 0; i < 16; i++) mm[i] = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      ep = (tl == 1) && !mw;
      ed = (tl == 1) && mw;
      chk("rnd_busy", busy, tl > 0);
      chk("rnd_mem_we", mem_we, (tl == RL + 1) && mwe);
      chk("rnd_p_ack", p_ack, ep);
      chk("rnd_d_ack", d_ack, ed);
      chk("rnd_p_stall", p_stall, p_req && !ep);
      chk("rnd_p_rdata", p_rdata, mrd[0]);
      chk("rnd_d_rdata", d_rdata, mrd[1]);
      chk("rnd_mem_addr", mem_addr, maddr);
      chk("rnd_mem_wdata", mem_wdata, mwdata);
      if (ep || !p_req) begin
        p_req = ($urandom % 3) != 0; p_we = $urandom % 2; p_addr = $urandom; p_wdata = $urandom;
      end else if ($urandom % 20 == 0) p_req = 1'b0;
      if (ed || !d_req) begin
        d_req = ($urandom % 2) != 0; d_we = $urandom % 2; d_addr = $urandom; d_wdata = $urandom;
      end else if ($urandom % 20 == 0) d_req = 1'b0;
      @(posedge CLK);
      was_idle = (tl == 0);
      gd = 1'b0;
      if (was_idle) begin
        if (p_req || d_req) begin
`ifdef ARB_RR_EN
          gd = d_req && (!p_req || !mlast);
          mlast = gd;
`else
          gd = d_req && (!p_req || ms == SM);
`endif
          mw = gd; mwe = gd ? d_we : p_we;
          maddr = gd ? d_addr : p_addr; mwdata = gd ? d_wdata : p_wdata;
          tl = RL + 1;
        end
      end else begin
        if (tl == RL + 1 && mwe) mm[maddr[3:0]] = mwdata;
        if (tl == 2 && !mwe) mrd[mw] = mm[maddr[3:0]];
        tl--;
      end
      if (!d_req) ms = 0;
      else if (was_idle) ms = gd ? 0 : ms + 1;
      @(negedge CLK);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errs, checks);
    $fatal(1, "watchdog");
  end
endmodule
